// File: rtl/gt_pattern_sequencer.sv
// Read-address sequencer for the six-bank pattern SDPRAM feeding the GT stream.
// Define GT_SEQ_GAP_EN to build the cfg_gap port and the inter-pass idle gap.
module gt_pattern_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LOOP_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              gt_clk,
  input  logic              gt_rstb,
  input  logic              start,
  input  logic              stop,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic [LOOP_W-1:0] cfg_loops,
`ifdef GT_SEQ_GAP_EN
  input  logic [7:0]        cfg_gap,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              data_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic              done,
  output logic [LOOP_W-1:0] pass_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
`ifdef GT_SEQ_GAP_EN
    ST_GAP    = 2'd3,
`endif
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LOOP_W-1:0] LOOP_ZERO = {LOOP_W{1'b0}};
  localparam logic [LOOP_W-1:0] LOOP_ONE  = {{(LOOP_W-1){1'b0}}, 1'b1};
  localparam logic [LOOP_W:0]   LOOP_ONE_X = {{LOOP_W{1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W-1:0] last_r;
  logic [LOOP_W-1:0] loops_r;
  logic              stop_pend_r;
  logic [RD_LAT-1:0] vld_pipe_r;
  logic [RD_LAT-1:0] sof_pipe_r;
  logic [RD_LAT-1:0] eof_pipe_r;
`ifdef GT_SEQ_GAP_EN
  logic [7:0]        gap_r;
  logic [7:0]        gap_cnt_r;
`endif

  logic              at_last_s;
  logic              stop_now_s;
  logic              final_pass_s;
  logic              pass_sat_s;
  logic              drained_s;
  logic [LOOP_W:0]   pass_inc_s;

  // A stop arriving on the last word of a pass still ends playback at that word.
  assign at_last_s    = (rd_addr == last_r);
  assign stop_now_s   = stop_pend_r | stop;
  assign pass_inc_s   = {1'b0, pass_cnt} + LOOP_ONE_X;
  assign final_pass_s = (loops_r != LOOP_ZERO) && (pass_inc_s == {1'b0, loops_r});
  assign pass_sat_s   = &pass_cnt;
  assign drained_s    = (vld_pipe_r == {RD_LAT{1'b0}});

  assign data_valid = vld_pipe_r[RD_LAT-1];
  assign sof        = sof_pipe_r[RD_LAT-1];
  assign eof        = eof_pipe_r[RD_LAT-1];

  // Playback state machine with registered read-port and status outputs.
  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      state_r     <= ST_IDLE;
      rd_addr     <= ADDR_ZERO;
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass_cnt    <= LOOP_ZERO;
      last_r      <= ADDR_ZERO;
      loops_r     <= LOOP_ZERO;
      stop_pend_r <= 1'b0;
`ifdef GT_SEQ_GAP_EN
      gap_r       <= 8'd0;
      gap_cnt_r   <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          rd_en       <= 1'b0;
          busy        <= 1'b0;
          stop_pend_r <= 1'b0;
          if (start && !stop && !abort) begin
            state_r  <= ST_RUN;
            rd_addr  <= ADDR_ZERO;
            rd_en    <= 1'b1;
            busy     <= 1'b1;
            pass_cnt <= LOOP_ZERO;
            last_r   <= cfg_last;
            loops_r  <= cfg_loops;
`ifdef GT_SEQ_GAP_EN
            gap_r    <= cfg_gap;
`endif
          end
        end
        ST_RUN: begin
          if (stop) begin
            stop_pend_r <= 1'b1;
          end
          if (abort) begin
            state_r <= ST_FINISH;
            rd_en   <= 1'b0;
          end else if (at_last_s) begin
            if (!pass_sat_s) begin
              pass_cnt <= pass_cnt + LOOP_ONE;
            end
            if (stop_now_s || final_pass_s) begin
              state_r <= ST_FINISH;
              rd_en   <= 1'b0;
`ifdef GT_SEQ_GAP_EN
            end else if (gap_r != 8'd0) begin
              state_r   <= ST_GAP;
              rd_en     <= 1'b0;
              gap_cnt_r <= gap_r;
`endif
            end else begin
              rd_addr <= ADDR_ZERO;
            end
          end else begin
            rd_addr <= rd_addr + ADDR_ONE;
          end
        end
`ifdef GT_SEQ_GAP_EN
        ST_GAP: begin
          rd_en <= 1'b0;
          if (stop) begin
            stop_pend_r <= 1'b1;
          end
          if (abort) begin
            state_r <= ST_FINISH;
          end else if (gap_cnt_r == 8'd1) begin
            if (stop_now_s) begin
              state_r <= ST_FINISH;
            end else begin
              state_r <= ST_RUN;
              rd_addr <= ADDR_ZERO;
              rd_en   <= 1'b1;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end
`endif
        ST_FINISH: begin
          rd_en <= 1'b0;
          if (done) begin
            state_r     <= ST_IDLE;
            busy        <= 1'b0;
            stop_pend_r <= 1'b0;
          end else if (drained_s) begin
            done <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rd_en   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency delay line aligning valid/sof/eof with RAM doutb.
  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      vld_pipe_r <= {RD_LAT{1'b0}};
      sof_pipe_r <= {RD_LAT{1'b0}};
      eof_pipe_r <= {RD_LAT{1'b0}};
    end else begin
      vld_pipe_r[0] <= rd_en;
      sof_pipe_r[0] <= rd_en && (rd_addr == ADDR_ZERO);
      eof_pipe_r[0] <= rd_en && at_last_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i-1];
        sof_pipe_r[i] <= sof_pipe_r[i-1];
        eof_pipe_r[i] <= eof_pipe_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_gt_pattern_sequencer.sv
// Self-checking bench for gt_pattern_sequencer: directed and randomized playback runs
// compared cycle by cycle against a pass-level expected read trace.
module tb_gt_pattern_sequencer;
  localparam int ADDR_W = 8;
  localparam int LOOP_W = 4;
  localparam int RD_LAT = 2;
  localparam int PC_MAX = (1 << LOOP_W) - 1;

  logic              gt_clk = 1'b0;
  logic              gt_rstb = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] cfg_last = '0;
  logic [LOOP_W-1:0] cfg_loops = '0;
`ifdef GT_SEQ_GAP_EN
  logic [7:0]        cfg_gap = '0;
`endif
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en, data_valid, sof, eof, busy, done;
  logic [LOOP_W-1:0] pass_cnt;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Expected trace, one entry per cycle from the first RUN cycle to the last read.
  int exp_en[$];
  int exp_addr[$];
  int exp_pc[$];
  int final_pc;
  int last_idx;

  gt_pattern_sequencer #(.ADDR_W(ADDR_W), .LOOP_W(LOOP_W), .RD_LAT(RD_LAT)) dut (
    .gt_clk(gt_clk), .gt_rstb(gt_rstb), .start(start), .stop(stop), .abort(abort),
    .cfg_last(cfg_last), .cfg_loops(cfg_loops),
`ifdef GT_SEQ_GAP_EN
    .cfg_gap(cfg_gap),
`endif
    .rd_addr(rd_addr), .rd_en(rd_en), .data_valid(data_valid), .sof(sof), .eof(eof),
    .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 gt_clk = ~gt_clk;

  task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Passes of L+1 words, optional gap of G idle cycles, ended by loop count, stop or abort.
  task automatic build_model(input int L, input int N, input int G, input int stop_at, input int abort_at);
    int passes;
    int t;
    bit fin;
    exp_en.delete(); exp_addr.delete(); exp_pc.delete();
    passes = 0; t = 0; fin = 1'b0;
    while (!fin && t < 4000) begin
      for (int a = 0; a <= L && !fin; a++) begin
        exp_en.push_back(1); exp_addr.push_back(a); exp_pc.push_back(passes);
        if (abort_at == t) fin = 1'b1;
        else if (a == L) begin
          if (passes < PC_MAX) passes++;
          if ((stop_at >= 0 && stop_at <= t) || (N != 0 && passes == N)) fin = 1'b1;
        end
        t++;
      end
      if (!fin) begin
        for (int g = 0; g < G; g++) begin
          exp_en.push_back(0); exp_addr.push_back(0); exp_pc.push_back(passes);
          t++;
        end
      end
    end
    final_pc = passes;
    last_idx = exp_en.size() - 1;
  endtask

  task automatic run_scenario(input string name, input int L, input int N, input int G,
                              input int stop_at, input int abort_at);
    int dv_i;
    int end_t;
    int e_dv, e_sof, e_eof;
    build_model(L, N, G, stop_at, abort_at);
    end_t = last_idx + RD_LAT + 3;
    cfg_last = ADDR_W'(L);
    cfg_loops = LOOP_W'(N);
`ifdef GT_SEQ_GAP_EN
    cfg_gap = 8'(G);
`endif
    start = 1'b1;
    @(posedge gt_clk); #1;
    start = 1'b0;
    for (int t = 0; t <= end_t; t++) begin
      dv_i = t - RD_LAT;
      e_dv = 0; e_sof = 0; e_eof = 0;
      if (dv_i >= 0 && dv_i <= last_idx && exp_en[dv_i] != 0) begin
        e_dv = 1;
        e_sof = (exp_addr[dv_i] == 0) ? 1 : 0;
        e_eof = (exp_addr[dv_i] == L) ? 1 : 0;
      end
      check({name, " rd_en"}, t, 32'(rd_en), (t <= last_idx) ? exp_en[t] : 0);
      if (t <= last_idx && exp_en[t] != 0) check({name, " rd_addr"}, t, 32'(rd_addr), exp_addr[t]);
      check({name, " data_valid"}, t, 32'(data_valid), e_dv);
      check({name, " sof"}, t, 32'(sof), e_sof);
      check({name, " eof"}, t, 32'(eof), e_eof);
      check({name, " busy"}, t, 32'(busy), (t < end_t) ? 1 : 0);
      check({name, " done"}, t, 32'(done), (t == end_t - 1) ? 1 : 0);
      check({name, " pass_cnt"}, t, 32'(pass_cnt), (t <= last_idx) ? exp_pc[t] : final_pc);
      // Config churn and stray starts while busy must be ignored.
      stop = (t == stop_at);
      abort = (t == abort_at);
      cfg_last = ADDR_W'($urandom);
      cfg_loops = LOOP_W'($urandom);
      start = (t < end_t) && ($urandom_range(0, 7) == 0);
      @(posedge gt_clk); #1;
    end
    stop = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check({name, " rd_en"}, i, 32'(rd_en), 0);
      check({name, " data_valid"}, i, 32'(data_valid), 0);
      check({name, " busy"}, i, 32'(busy), 0);
      check({name, " done"}, i, 32'(done), 0);
      @(posedge gt_clk); #1;
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " rd_addr"}, 0, 32'(rd_addr), 0);
    check({name, " rd_en"}, 0, 32'(rd_en), 0);
    check({name, " data_valid"}, 0, 32'(data_valid), 0);
    check({name, " sof"}, 0, 32'(sof), 0);
    check({name, " eof"}, 0, 32'(eof), 0);
    check({name, " busy"}, 0, 32'(busy), 0);
    check({name, " done"}, 0, 32'(done), 0);
    check({name, " pass_cnt"}, 0, 32'(pass_cnt), 0);
  endtask

  initial begin
    repeat (3) @(posedge gt_clk);
    #1;
    check_reset_vals("reset");
    @(negedge gt_clk); gt_rstb = 1'b1;
    @(posedge gt_clk); #1;
    check_idle("post_reset", 2);

    run_scenario("loop2", 3, 2, 0, -1, -1);
    check("loop2 final pass_cnt", 0, 32'(pass_cnt), 2);
    run_scenario("stop", 7, 0, 0, 18, -1);
    check("stop final pass_cnt", 0, 32'(pass_cnt), 3);
    run_scenario("abort", 9, 0, 0, -1, 5);
    check("abort final pass_cnt", 0, 32'(pass_cnt), 0);
`ifdef GT_SEQ_GAP_EN
    run_scenario("gap", 1, 3, 4, -1, -1);
    check("gap final pass_cnt", 0, 32'(pass_cnt), 3);
`endif
    run_scenario("last0", 0, 5, 0, -1, -1);
    check("last0 final pass_cnt", 0, 32'(pass_cnt), 5);
    run_scenario("saturate", 0, 0, 0, 20, -1);
    check("saturate final pass_cnt", 0, 32'(pass_cnt), PC_MAX);

    // start colliding with abort or stop in IDLE, and lone stop/abort, do nothing.
    cfg_last = 8'd3; cfg_loops = 4'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge gt_clk); #1;
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort", 4);
    start = 1'b1; stop = 1'b1;
    @(posedge gt_clk); #1;
    start = 1'b0; stop = 1'b0;
    check_idle("start_stop", 4);
    stop = 1'b1;
    @(posedge gt_clk); #1;
    stop = 1'b0; abort = 1'b1;
    @(posedge gt_clk); #1;
    abort = 1'b0;
    check_idle("idle_stop_abort", 3);
    run_scenario("after_idle_stop", 2, 2, 0, -1, -1);

    for (int r = 0; r < 20; r++) begin
      int rl, rn, rs, ra, span;
      rl = $urandom_range(0, 6);
      rn = $urandom_range(0, 3);
      span = (rn == 0) ? 30 : (rl + 1) * rn;
      rs = -1;
      ra = -1;
      if (rn == 0 || $urandom_range(0, 1) == 1) rs = $urandom_range(0, span - 1);
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, span - 1);
      run_scenario("rand", rl, rn, 0, rs, ra);
    end

    // Asynchronous reset in the middle of a run.
    cfg_last = 8'd1; cfg_loops = 4'd0;
    start = 1'b1;
    @(posedge gt_clk); #1;
    start = 1'b0;
    repeat (5) @(posedge gt_clk);
    #3;
    gt_rstb = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge gt_clk); gt_rstb = 1'b1;
    @(posedge gt_clk); #1;
    check_idle("after_midrun_reset", 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/gt_pattern_sequencer.md
Name: gt_pattern_sequencer

Overview:
- Playback controller in the gt_clk domain that sequences read addresses for the six-bank 256-deep pattern SDPRAM feeding the 192-bit GT stream.
- Supports single-pass, N-pass and infinite-loop playback, with configurable idle gaps between passes and graceful or immediate stop.
- Generates rd_addr/rd_en for the RAM read port, plus data_valid, sof and eof markers aligned to the RAM read latency.
- All control inputs arrive already synchronized into gt_clk by the register block.

Parameters:
- ADDR_W, 8, RAM read address width.
- LOOP_W, 16, width of pass count and pass counter.
- RD_LAT, 1, RAM read latency in cycles (addrb to doutb); must be 1..4.

Ports:
- gt_clk  in  1  GT clock, 187.5 MHz.
- gt_rstb  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins playback.
- stop  in  1  one-cycle pulse: graceful stop at the end of the current pass.
- abort  in  1  one-cycle pulse: immediate stop.
- cfg_last  in  ADDR_W  last RAM address of the pattern; pass length = cfg_last+1.
- cfg_loops  in  LOOP_W  number of passes; 0 = infinite.
- cfg_gap  in  8  idle cycles between passes (GT_SEQ_GAP_EN builds only).
- rd_addr  out  ADDR_W  RAM read address.
- rd_en  out  1  read address valid this cycle.
- data_valid  out  1  RAM doutb valid (rd_en delayed by RD_LAT).
- sof  out  1  data_valid word is address 0 of a pass.
- eof  out  1  data_valid word is address cfg_last.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when playback ends (normal end, stop or abort).
- pass_cnt  out  LOOP_W  number of completed passes since the last start.

Behaviour:
- Reset: state IDLE; rd_addr=0, rd_en=0, data_valid=0, sof=0, eof=0, busy=0, done=0, pass_cnt=0; delay pipeline cleared.
- States are IDLE, RUN, GAP and FINISH.
- IDLE:
  - start (with no stop/abort in the same cycle) latches cfg_last, cfg_loops and cfg_gap, clears pass_cnt and goes to RUN. rd_addr=0 and rd_en=1 in the first RUN cycle.
  - stop or abort while IDLE is ignored.
- RUN:
  - rd_en=1; rd_addr increments by 1 per cycle.
  - At rd_addr==latched last:
    - pass_cnt is incremented.
    - If a stop is pending, or loops!=0 and pass_cnt+1==loops, go to FINISH.
    - Otherwise, if gap!=0, go to GAP.
    - Otherwise rd_addr wraps to 0 and RUN continues with no bubble.
  - cfg_last=0 gives a 1-word pass; rd_addr stays at 0.
- GAP:
  - rd_en=0; an 8-bit down-counter is loaded with gap.
  - After exactly gap idle cycles, return to RUN with rd_addr=0.
  - stop in GAP goes to FINISH at the end of the gap.
- FINISH:
  - rd_en=0; waits until the RD_LAT pipeline has drained (no data_valid outstanding).
  - Then pulses done for 1 cycle and goes to IDLE.
- stop: sets a sticky stop_pend flag that is cleared on entry to IDLE.
- abort (any state except IDLE):
  - Next cycle rd_en=0 and state is FINISH; the current pass is not counted.
  - Outstanding reads still drain with data_valid.
- Precedence when events coincide: abort > stop > start. start while busy is ignored.
- pass_cnt saturates at all-ones; it is held after done until the next start.
- Latency: data_valid/sof/eof equal rd_en/(rd_en&&rd_addr==0)/(rd_en&&rd_addr==last) delayed by exactly RD_LAT cycles.
- busy is 1 from the first RUN cycle through the done cycle inclusive.
- cfg_* changes while busy have no effect until the next start.

Optional Feature:
- Macro: GT_SEQ_GAP_EN.
- Defined: cfg_gap port present; GAP state and gap counter implemented as described above.
- Undefined: cfg_gap port absent; GAP state is not built; passes always wrap back-to-back.

Test Plan:
- cfg_last=3, cfg_loops=2, start → rd_addr 0,1,2,3,0,1,2,3 with rd_en high for 8 cycles; sof/eof each pulse twice, RD_LAT after the matching rd_en; pass_cnt=2; done pulses 1 cycle after the pipeline drains; busy then falls.
- cfg_loops=0, cfg_last=7, stop pulsed at rd_addr=2 of pass 3 → playback finishes at rd_addr 7; pass_cnt=3; done pulses once.
- abort at rd_addr=5, cfg_last=9 → rd_en=0 next cycle; the data_valid already in flight still appears (RD_LAT words); pass_cnt unchanged; done pulses.
- GT_SEQ_GAP_EN build, cfg_gap=4, cfg_last=1, cfg_loops=3 → pattern 0,1,gap×4,0,1,gap×4,0,1 then FINISH; no gap after the final pass.
- cfg_last=0, cfg_loops=5 → rd_addr holds 0 with rd_en high for 5 cycles; sof and eof both high on every valid word.
- start and abort in the same cycle while IDLE → stays IDLE; busy=0; no done. Assert gt_rstb low mid-RUN → all outputs return to reset values immediately.
